// File: rtl/controlador_estufa_multi.sv
// Multi-channel greenhouse controller.
// Each scan latches all channels and the plant type, then walks the channels
// one per clock to accumulate the sum and update each channel's persistence
// filter. The scan ends with one cycle that publishes the results.
// Output strobe: ciclo_valido is high for exactly one clock. In that clock,
// media, alarme, erro_tipo and both display buses hold the values of the scan
// that just finished. There is no back-pressure, so a consumer must sample the
// outputs while the strobe is high.
module controlador_estufa_multi #(
   parameter int N_CH    = 4,
   parameter int W       = 4,
   parameter int N_TIPOS = 4,
   parameter int PERSIST = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [3:0]          tipo_planta,
   input  logic [N_CH*W-1:0]   sensores,
   output logic [W-1:0]        media,
   output logic [N_CH-1:0]     alarme,
   output logic                erro_tipo,
   output logic                ciclo_valido,
   output logic [7*N_CH-1:0]   display_canais,
   output logic [6:0]          display_media,
   output logic [1:0]          estado_dbg
);

   localparam int LOG_N = $clog2(N_CH);
   localparam int IDX_W = (LOG_N > 0) ? LOG_N : 1;
   localparam int SUM_W = W + LOG_N;
   // The range limits are at most 8+15, so W+5 bits hold every comparison.
   localparam int LIM_W = W + 5;
   localparam logic [4:0]       N_TIPOS_L   = 5'(N_TIPOS);
   localparam logic [3:0]       PERSIST_L   = 4'(PERSIST);
   localparam logic [IDX_W-1:0] ULTIMO_IDX  = IDX_W'(N_CH - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURA  = 2'd1,
      VARRE    = 2'd2,
      ATUALIZA = 2'd3
   } estado_t;

   estado_t estado, prox_estado;

   logic [N_CH*W-1:0] sens_sh;
   logic [3:0]        tipo_sh;
   logic [SUM_W-1:0]  soma;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        cnt [N_CH];
   logic [N_CH-1:0]   alarm_int;

   // Signals for the channel that is currently being scanned.
   logic [W-1:0]      valor_atual;
   logic [LIM_W-1:0]  valor_ext;
   logic [LIM_W-1:0]  lim_min;
   logic [LIM_W-1:0]  lim_max;
   logic              tipo_inv;
   logic              fora;
   logic              discorda;
   logic [3:0]        cnt_inc;
   logic [W-1:0]      media_nova;

   assign estado_dbg = estado;

   // 7-segment decoder. The bit order is {g,f,e,d,c,b,a} and the outputs are active-high.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Classify the current channel against the captured plant type's range.
   always_comb begin
      valor_atual = sens_sh[idx*W +: W];
      valor_ext   = LIM_W'(valor_atual);
      tipo_inv    = ({1'b0, tipo_sh} >= N_TIPOS_L);
      lim_min     = LIM_W'(tipo_sh) + LIM_W'(4);
      lim_max     = LIM_W'(tipo_sh) + LIM_W'(8);
      fora        = (valor_ext < lim_min) || (valor_ext > lim_max);
      discorda    = (fora != alarm_int[idx]);
      cnt_inc     = cnt[idx] + 4'd1;
      media_nova  = W'(soma >> LOG_N);
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) estado <= IDLE;
      else        estado <= prox_estado;
   end

   // Next-state logic. A scan that has started always runs to its publish cycle.
   always_comb begin
      prox_estado = estado;
      case (estado)
         IDLE:     if (enable) prox_estado = CAPTURA;
         CAPTURA:  prox_estado = VARRE;
         VARRE:    if (idx == ULTIMO_IDX) prox_estado = ATUALIZA;
         ATUALIZA: prox_estado = enable ? CAPTURA : IDLE;
         default:  prox_estado = IDLE;
      endcase
   end

   // Datapath: capture, accumulate and filter, then publish the results.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sens_sh        <= '0;
         tipo_sh        <= '0;
         soma           <= '0;
         idx            <= '0;
         alarm_int      <= '0;
         media          <= '0;
         alarme         <= '0;
         erro_tipo      <= 1'b0;
         ciclo_valido   <= 1'b0;
         display_canais <= '0;
         display_media  <= '0;
         for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      end else begin
         ciclo_valido <= 1'b0;
         case (estado)
            CAPTURA: begin
               sens_sh <= sensores;
               tipo_sh <= tipo_planta;
               soma    <= '0;
               idx     <= '0;
            end
            VARRE: begin
               soma <= soma + SUM_W'(valor_atual);
               idx  <= idx + IDX_W'(1);
               // With an invalid plant type, the filter keeps its state unchanged.
               if (!tipo_inv) begin
                  if (discorda) begin
                     if (cnt_inc == PERSIST_L) begin
                        alarm_int[idx] <= ~alarm_int[idx];
                        cnt[idx]       <= '0;
                     end else begin
                        cnt[idx] <= cnt_inc;
                     end
                  end else begin
                     cnt[idx] <= '0;
                  end
               end
            end
            ATUALIZA: begin
               media        <= media_nova;
               alarme       <= alarm_int;
               erro_tipo    <= tipo_inv;
               ciclo_valido <= 1'b1;
               display_media <= tipo_inv ? 7'h79 : seg7(media_nova[W-1 -: 4]);
               for (int i = 0; i < N_CH; i++)
                  display_canais[i*7 +: 7] <= seg7(sens_sh[i*W + W - 4 +: 4]);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_controlador_estufa_multi.sv
// Bench for controlador_estufa_multi with the default parameters (4 channels, 4 bits).
// A table of back-to-back scans is followed by hand sequences for enable drop,
// cadence and mid-scan reset.
module tb_controlador_estufa_multi;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [3:0]  tipo_planta;
   logic [15:0] sensores;
   logic [3:0]  media;
   logic [3:0]  alarme;
   logic        erro_tipo;
   logic        ciclo_valido;
   logic [27:0] display_canais;
   logic [6:0]  display_media;
   logic [1:0]  estado_dbg;

   int n_chk  = 0;
   int n_pass = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic [3:0]  tipo;
      logic [15:0] sens;
      logic [3:0]  media;
      logic [3:0]  alarme;
      logic        erro;
      logic [6:0]  dm;
      logic [27:0] dc;
   } vec_t;

   vec_t vecs[26];

   controlador_estufa_multi dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .tipo_planta    (tipo_planta),
      .sensores       (sensores),
      .media          (media),
      .alarme         (alarme),
      .erro_tipo      (erro_tipo),
      .ciclo_valido   (ciclo_valido),
      .display_canais (display_canais),
      .display_media  (display_media),
      .estado_dbg     (estado_dbg)
   );

   // Clock and reset.
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic [3:0] t, input logic [15:0] s, input logic [3:0] m,
                               input logic [3:0] a, input logic e, input logic [6:0] dm,
                               input logic [27:0] dc);
      vec_t v;
      v.tipo = t; v.sens = s; v.media = m; v.alarme = a; v.erro = e; v.dm = dm; v.dc = dc;
      return v;
   endfunction

   // Driver: present inputs and wait, with a bound, for the next strobe. lat counts negedges.
   task automatic run_scan(input logic [3:0] t, input logic [15:0] s, output int lat);
      tipo_planta = t;
      sensores    = s;
      enable      = 1'b1;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!ciclo_valido && lat < 40);
      if (!ciclo_valido) chk("scan_timeout", 32'd0, 32'd1);
   endtask

   task automatic count_pulses(input int n, output int p);
      p = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         if (ciclo_valido) p++;
      end
   endtask

   initial begin
      int lat;
      int pulses;
      logic [3:0] e;

      // Each row is one scan. Rows run back to back while enable stays high.
      vecs[0]  = mk(4'd0, 16'h6886, 4'd7, 4'h0, 1'b0, 7'h07, {7'h7D, 7'h7F, 7'h7F, 7'h7D});
      vecs[1]  = mk(4'd1, 16'h4415, 4'd3, 4'h0, 1'b0, 7'h4F, {7'h66, 7'h66, 7'h06, 7'h6D});
      vecs[2]  = mk(4'd1, 16'h4415, 4'd3, 4'h0, 1'b0, 7'h4F, {7'h66, 7'h66, 7'h06, 7'h6D});
      vecs[3]  = mk(4'd1, 16'h4415, 4'd3, 4'hE, 1'b0, 7'h4F, {7'h66, 7'h66, 7'h06, 7'h6D});
      vecs[4]  = mk(4'd1, 16'h6666, 4'd6, 4'hE, 1'b0, 7'h7D, {4{7'h7D}});
      vecs[5]  = mk(4'd1, 16'h6666, 4'd6, 4'hE, 1'b0, 7'h7D, {4{7'h7D}});
      vecs[6]  = mk(4'd1, 16'h6666, 4'd6, 4'h0, 1'b0, 7'h7D, {4{7'h7D}});
      vecs[7]  = mk(4'd1, 16'h4415, 4'd3, 4'h0, 1'b0, 7'h4F, {7'h66, 7'h66, 7'h06, 7'h6D});
      vecs[8]  = mk(4'd1, 16'h4415, 4'd3, 4'h0, 1'b0, 7'h4F, {7'h66, 7'h66, 7'h06, 7'h6D});
      vecs[9]  = mk(4'd1, 16'h4415, 4'd3, 4'hE, 1'b0, 7'h4F, {7'h66, 7'h66, 7'h06, 7'h6D});
      vecs[10] = mk(4'd1, 16'h6666, 4'd6, 4'hE, 1'b0, 7'h7D, {4{7'h7D}});
      vecs[11] = mk(4'd1, 16'h6616, 4'd4, 4'hE, 1'b0, 7'h66, {7'h7D, 7'h7D, 7'h06, 7'h7D});
      vecs[12] = mk(4'd1, 16'h6666, 4'd6, 4'h2, 1'b0, 7'h7D, {4{7'h7D}});
      vecs[13] = mk(4'd1, 16'h6666, 4'd6, 4'h2, 1'b0, 7'h7D, {4{7'h7D}});
      vecs[14] = mk(4'd1, 16'h6666, 4'd6, 4'h0, 1'b0, 7'h7D, {4{7'h7D}});
      vecs[15] = mk(4'd1, 16'h4415, 4'd3, 4'h0, 1'b0, 7'h4F, {7'h66, 7'h66, 7'h06, 7'h6D});
      vecs[16] = mk(4'd1, 16'h4415, 4'd3, 4'h0, 1'b0, 7'h4F, {7'h66, 7'h66, 7'h06, 7'h6D});
      vecs[17] = mk(4'd1, 16'h4415, 4'd3, 4'hE, 1'b0, 7'h4F, {7'h66, 7'h66, 7'h06, 7'h6D});
      vecs[18] = mk(4'd5, 16'h6666, 4'd6, 4'hE, 1'b1, 7'h79, {4{7'h7D}});
      vecs[19] = mk(4'd5, 16'h6666, 4'd6, 4'hE, 1'b1, 7'h79, {4{7'h7D}});
      vecs[20] = mk(4'd5, 16'h6666, 4'd6, 4'hE, 1'b1, 7'h79, {4{7'h7D}});
      vecs[21] = mk(4'd0, 16'h6666, 4'd6, 4'hE, 1'b0, 7'h7D, {4{7'h7D}});
      vecs[22] = mk(4'd4, 16'hF0F0, 4'd7, 4'hE, 1'b1, 7'h79, {7'h71, 7'h3F, 7'h71, 7'h3F});
      vecs[23] = mk(4'd0, 16'h4839, 4'd6, 4'hE, 1'b0, 7'h7D, {7'h66, 7'h7F, 7'h4F, 7'h6F});
      vecs[24] = mk(4'd0, 16'h4839, 4'd6, 4'h2, 1'b0, 7'h7D, {7'h66, 7'h7F, 7'h4F, 7'h6F});
      vecs[25] = mk(4'd0, 16'h4839, 4'd6, 4'h3, 1'b0, 7'h7D, {7'h66, 7'h7F, 7'h4F, 7'h6F});

      // Reset state.
      reset = 1'b0; enable = 1'b0; tipo_planta = 4'd0; sensores = 16'h0;
      repeat (3) @(negedge clock);
      chk("rst_media", 32'(media), 32'h0);
      chk("rst_alarme", 32'(alarme), 32'h0);
      chk("rst_erro", 32'(erro_tipo), 32'h0);
      chk("rst_ciclo", 32'(ciclo_valido), 32'h0);
      chk("rst_dc", 32'(display_canais), 32'h0);
      chk("rst_dm", 32'(display_media), 32'h0);
      chk("rst_estado", 32'(estado_dbg), 32'h0);
      reset = 1'b1;
      @(negedge clock);

      // Table of scans.
      for (int i = 0; i < 26; i++) begin
         run_scan(vecs[i].tipo, vecs[i].sens, lat);
         chk($sformatf("v%0d_lat", i), 32'(lat), (i == 0) ? 32'd7 : 32'd6);
         chk($sformatf("v%0d_media", i), 32'(media), 32'(vecs[i].media));
         chk($sformatf("v%0d_alarme", i), 32'(alarme), 32'(vecs[i].alarme));
         chk($sformatf("v%0d_erro", i), 32'(erro_tipo), 32'(vecs[i].erro));
         chk($sformatf("v%0d_dm", i), 32'(display_media), 32'(vecs[i].dm));
         chk($sformatf("v%0d_dc", i), 32'(display_canais), 32'(vecs[i].dc));
      end

      // enable falls during a scan: exactly one more strobe, then the FSM settles in IDLE.
      repeat (2) @(negedge clock);
      enable = 1'b0;
      count_pulses(30, pulses);
      chk("drop_pulses", 32'(pulses), 32'd1);
      chk("drop_media", 32'(media), 32'd6);
      chk("drop_idle", 32'(estado_dbg), 32'd0);

      // Back-to-back cadence: one-cycle strobes spaced 6 clocks apart.
      exp_q.push_back(4'd7);
      run_scan(4'd0, 16'h6886, lat);
      chk("b2b_first_lat", 32'(lat), 32'd7);
      e = exp_q.pop_front();
      chk("b2b_media0", 32'(media), 32'(e));
      for (int k = 1; k < 4; k++) begin
         exp_q.push_back(4'd7);
         @(negedge clock);
         chk($sformatf("b2b_width%0d", k), 32'(ciclo_valido), 32'd0);
         lat = 1;
         while (!ciclo_valido && lat < 40) begin
            @(negedge clock);
            lat++;
         end
         chk($sformatf("b2b_period%0d", k), 32'(lat), 32'd6);
         e = exp_q.pop_front();
         chk($sformatf("b2b_media%0d", k), 32'(media), 32'(e));
      end
      enable = 1'b0;
      repeat (12) @(negedge clock);

      // Reset in the middle of a scan aborts the scan with no strobe.
      run_scan_start: begin
         tipo_planta = 4'd1; sensores = 16'h4415; enable = 1'b1;
         repeat (3) @(negedge clock);
         chk("mid_in_varre", 32'(estado_dbg), 32'd2);
         reset = 1'b0; enable = 1'b0;
         @(negedge clock);
         chk("mid_rst_media", 32'(media), 32'h0);
         chk("mid_rst_dc", 32'(display_canais), 32'h0);
         chk("mid_rst_dm", 32'(display_media), 32'h0);
         chk("mid_rst_ciclo", 32'(ciclo_valido), 32'h0);
         chk("mid_rst_estado", 32'(estado_dbg), 32'h0);
         reset = 1'b1;
         count_pulses(15, pulses);
         chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
      end

      // Final report.
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/controlador_estufa_multi.md
Name: controlador_estufa_multi

Overview:
Parametrised successor to the greenhouse controller. Samples N_CH sensor channels of W bits, scans them sequentially against a per-plant-type acceptance range and computes their average. Each channel has a persistence-filtered alarm, so a single out-of-range scan does not toggle it. Drives one 7-segment display per channel plus an average display, and sits between the sensor front-end and the board displays/actuators.

Parameters:
N_CH, 4, number of sensor channels (power of two, 1..16)
W, 4, sensor value width in bits (4..8)
N_TIPOS, 4, number of valid plant types
PERSIST, 3, consecutive scans needed to set or clear an alarm (1..15)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
enable  input  1  start/continue scanning
tipo_planta  input  4  plant type selector
sensores  input  N_CH*W  packed sensor values, channel i at [i*W +: W]
media  output  W  floor average of last captured set
alarme  output  N_CH  per-channel filtered alarm
erro_tipo  output  1  tipo_planta >= N_TIPOS at last capture
ciclo_valido  output  1  one-cycle pulse when outputs update
display_canais  output  7*N_CH  per-channel segments, channel i at [i*7 +: 7]
display_media  output  7  segments for media

Behaviour:
- All state updates on rising clock edges only. reset==0 at an edge forces every output and internal register to its reset value.
- Reset values: media=0, alarme=0, erro_tipo=0, ciclo_valido=0, all displays 7'h00 (blank), persistence counters=0, FSM=IDLE.
- Acceptance range for type t < N_TIPOS, identical for all channels: min = 4+t, max = 8+t, inclusive. Compare at W bits, zero-extended.
- FSM states:
  - IDLE: when enable==1 -> CAPTURA; otherwise hold.
  - CAPTURA (1 cycle): latch sensores and tipo_planta into shadow registers, clear the sum accumulator, set the channel index to 0 -> VARRE.
  - VARRE (N_CH cycles, one channel per cycle, index 0 upward): add the value to the sum (width W+log2(N_CH), no overflow) and update that channel's persistence counter. After the last channel -> ATUALIZA.
  - ATUALIZA (1 cycle): register media = sum >> log2(N_CH) (truncating), register alarme and erro_tipo, update displays, pulse ciclo_valido for exactly this cycle's output period. Then -> CAPTURA if enable==1, else -> IDLE.
- Latency: enable sampled high in IDLE -> ciclo_valido high N_CH+2 edges later. Back-to-back cycles repeat every N_CH+2 clocks.
- Persistence, per channel, with alarm state a and counter c:
  - When the in/out status disagrees with a, c increments.
  - When c reaches PERSIST, a toggles and c clears.
  - When the status agrees with a, c clears.
  - The new a becomes visible on alarme at ATUALIZA.
- Invalid type (captured tipo >= N_TIPOS): erro_tipo=1, alarme and persistence counters frozen, media still computed, display_media shows 'E' (7'h79). Channel displays still show values.
- Displays: active-high, bit order {g,f,e,d,c,b,a}. Each shows the hex digit of the top 4 bits of its W-bit value (the full value when W=4). Codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Input changes during VARRE/ATUALIZA are ignored; only captured values are used.
- enable falling mid-scan: the current scan completes and updates outputs, then the FSM goes to IDLE.
- Reset mid-scan: the scan is aborted, no ciclo_valido pulse, all reset values apply.

Test Plan:
- Defaults; tipo=0, sensores={6,8,8,6} (ch3..ch0), enable=1 -> ciclo_valido at edge 6 after enable, media=7, display_media=7'h07, alarme=0, display_canais={7D,7F,7F,7D}.
- tipo=1 (range 5..9), sensores={4,4,1,5}, enable held high -> alarme=0000 after scans 1 and 2, alarme=1110 after scan 3. media=(14>>2)=3, display_media=7'h4F.
- Alarm clear: after the previous case set sensores={6,6,6,6} -> alarme stays 1110 for 2 scans and becomes 0000 on scan 3. A one-scan glitch back to ch1=1 between good scans resets the counter and adds one scan of delay.
- tipo=5 -> erro_tipo=1, display_media=7'h79, alarme unchanged from prior value. Return to tipo=0 -> erro_tipo=0 on the next ciclo_valido.
- enable dropped during VARRE -> exactly one ciclo_valido, then the FSM stays in IDLE with no further pulses. reset=0 asserted during VARRE -> no pulse, all outputs return to reset values on the next edge.
- Back-to-back: enable high for 4 scans -> ciclo_valido pulses exactly every 6 clocks, each one cycle wide.
